// File: rtl/regfile_wr_queue.sv
// ============================================================================
// regfile_wr_queue : in-order write queue in front of a small register array,
//                    with youngest-entry read forwarding.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_wr_queue #(
  parameter int               WIDTH  = 16,
  parameter int               NREGS  = 2,
  parameter int               ADDR_W = 1,
  parameter int               DEPTH  = 4,
  parameter logic [WIDTH-1:0] INIT   = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     drain_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   pend_count,
  output logic                     commit_valid,
  output logic [ADDR_W-1:0]        commit_addr,
  output logic                     err_oor
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W:0]   NREGS_C = (ADDR_W+1)'(NREGS);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [WIDTH-1:0]  data_q [DEPTH];
  logic [WIDTH-1:0]  data_d [DEPTH];
  logic [WIDTH-1:0]  regs_q [NREGS];
  logic [WIDTH-1:0]  regs_d [NREGS];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              commit_valid_q, commit_valid_d;
  logic [ADDR_W-1:0] commit_addr_q, commit_addr_d;
  logic              err_oor_q, err_oor_d;

  logic              do_enq;
  logic              do_commit;
  logic [ADDR_W-1:0] head_addr;
  logic [WIDTH-1:0]  head_data;
  logic              head_in_range;

  assign wr_ready      = (count_q < DEPTH_C);
  assign do_enq        = wr_valid && wr_ready;
  assign do_commit     = drain_en && (count_q != '0);
  assign head_addr     = addr_q[head_q];
  assign head_data     = data_q[head_q];
  assign head_in_range = ({1'b0, head_addr} < NREGS_C);

  always_comb begin
    addr_d         = addr_q;
    data_d         = data_q;
    regs_d         = regs_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = do_commit;
    commit_addr_d  = commit_addr_q;
    err_oor_d      = err_oor_q;

    if (do_enq) begin
      addr_d[tail_q] = wr_addr;
      data_d[tail_q] = wr_data;
      tail_d         = tail_q + PTR_W'(1);
    end

    if (do_commit) begin
      head_d        = head_q + PTR_W'(1);
      commit_addr_d = head_addr;
      if (head_in_range) begin
        for (int r = 0; r < NREGS; r++) begin
          if (head_addr == ADDR_W'(r)) regs_d[r] = head_data;
        end
      end else begin
        err_oor_d = 1'b1;
      end
    end

    // Simultaneous enqueue and commit leave the occupancy unchanged.
    case ({do_enq, do_commit})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      for (int r = 0; r < NREGS; r++) regs_q[r] <= INIT;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_addr_q  <= '0;
      err_oor_q      <= 1'b0;
    end else begin
      addr_q         <= addr_d;
      data_q         <= data_d;
      regs_q         <= regs_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_addr_q  <= commit_addr_d;
      err_oor_q      <= err_oor_d;
    end
  end

  logic             fwd_hit;
  logic [WIDTH-1:0] fwd_data;
  logic [WIDTH-1:0] arr_data;

  // Walk oldest to youngest so the youngest matching entry is the last one kept.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) &&
          (addr_q[PTR_W'(head_q + PTR_W'(i))] == rd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[PTR_W'(head_q + PTR_W'(i))];
      end
    end
  end

  always_comb begin
    arr_data = '0;
    for (int r = 0; r < NREGS; r++) begin
      if (rd_addr == ADDR_W'(r)) arr_data = regs_q[r];
    end
  end

  assign rd_data      = fwd_hit ? fwd_data : arr_data;
  assign pend_count   = count_q;
  assign commit_valid = commit_valid_q;
  assign commit_addr  = commit_addr_q;
  assign err_oor      = err_oor_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_queue.sv
// ============================================================================
// tb_regfile_wr_queue : directed self-checking bench for regfile_wr_queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wr_queue;

  logic        clk = 1'b0;
  logic        reset;

  // Default configuration: NREGS=2, ADDR_W=1
  logic        a_wr_valid, a_wr_ready, a_drain_en, a_commit_valid, a_err_oor;
  logic        a_wr_addr, a_rd_addr, a_commit_addr;
  logic [15:0] a_wr_data, a_rd_data;
  logic [2:0]  a_pend_count;

  // Out-of-range configuration: NREGS=3, ADDR_W=2
  logic        b_wr_valid, b_wr_ready, b_drain_en, b_commit_valid, b_err_oor;
  logic [1:0]  b_wr_addr, b_rd_addr, b_commit_addr;
  logic [15:0] b_wr_data, b_rd_data;
  logic [2:0]  b_pend_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_wr_queue #(.WIDTH(16), .NREGS(2), .ADDR_W(1), .DEPTH(4), .INIT(16'h0000)) dut_a (
    .clk(clk), .reset(reset),
    .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .drain_en(a_drain_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .pend_count(a_pend_count), .commit_valid(a_commit_valid),
    .commit_addr(a_commit_addr), .err_oor(a_err_oor)
  );

  regfile_wr_queue #(.WIDTH(16), .NREGS(3), .ADDR_W(2), .DEPTH(4), .INIT(16'h0000)) dut_b (
    .clk(clk), .reset(reset),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .drain_en(b_drain_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .pend_count(b_pend_count), .commit_valid(b_commit_valid),
    .commit_addr(b_commit_addr), .err_oor(b_err_oor)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    a_rd_addr = 1'b0; #1;
    checks++; if (a_rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd0 got=%h exp=0000", a_rd_data); end
    a_rd_addr = 1'b1; #1;
    checks++; if (a_rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd1 got=%h exp=0000", a_rd_data); end
    checks++; if (a_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", a_wr_ready); end
    checks++; if (a_pend_count !== 3'd0) begin errors++; $display("FAIL reset_pend got=%0d exp=0", a_pend_count); end
    checks++; if (a_commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid got=%b exp=0", a_commit_valid); end
    checks++; if (a_err_oor !== 1'b0) begin errors++; $display("FAIL reset_err_oor got=%b exp=0", a_err_oor); end
    checks++; if (b_err_oor !== 1'b0) begin errors++; $display("FAIL reset_b_err_oor got=%b exp=0", b_err_oor); end
  endtask

  task automatic test_fill();
    logic        addrs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] datas [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    a_drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_wr_valid = 1'b1;
      a_wr_addr  = addrs[i];
      a_wr_data  = datas[i];
      tick();
      checks++; if (a_pend_count !== 3'(i + 1)) begin errors++; $display("FAIL fill_pend[%0d] got=%0d exp=%0d", i, a_pend_count, i + 1); end
    end
    checks++; if (a_wr_ready !== 1'b0) begin errors++; $display("FAIL fill_wr_ready got=%b exp=0", a_wr_ready); end
    a_rd_addr = 1'b0; #1;
    checks++; if (a_rd_data !== 16'h3333) begin errors++; $display("FAIL fill_fwd_rd0 got=%h exp=3333", a_rd_data); end
    a_rd_addr = 1'b1; #1;
    checks++; if (a_rd_data !== 16'h4444) begin errors++; $display("FAIL fill_fwd_rd1 got=%h exp=4444", a_rd_data); end
    // Fifth request must be refused while full.
    a_wr_addr = 1'b0;
    a_wr_data = 16'h5555;
    tick();
    a_wr_valid = 1'b0;
    checks++; if (a_pend_count !== 3'd4) begin errors++; $display("FAIL fill_overflow_pend got=%0d exp=4", a_pend_count); end
    a_rd_addr = 1'b0; #1;
    checks++; if (a_rd_data !== 16'h3333) begin errors++; $display("FAIL fill_overflow_rd0 got=%h exp=3333", a_rd_data); end
  endtask

  task automatic test_drain();
    logic exp_addr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    a_drain_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (a_commit_valid !== 1'b1) begin errors++; $display("FAIL drain_cv[%0d] got=%b exp=1", k, a_commit_valid); end
      checks++; if (a_commit_addr !== exp_addr[k]) begin errors++; $display("FAIL drain_ca[%0d] got=%b exp=%b", k, a_commit_addr, exp_addr[k]); end
      checks++; if (a_pend_count !== 3'(3 - k)) begin errors++; $display("FAIL drain_pend[%0d] got=%0d exp=%0d", k, a_pend_count, 3 - k); end
    end
    tick();
    checks++; if (a_commit_valid !== 1'b0) begin errors++; $display("FAIL drain_cv_fall got=%b exp=0", a_commit_valid); end
    checks++; if (a_commit_addr !== 1'b1) begin errors++; $display("FAIL drain_ca_hold got=%b exp=1", a_commit_addr); end
    checks++; if (a_wr_ready !== 1'b1) begin errors++; $display("FAIL drain_wr_ready got=%b exp=1", a_wr_ready); end
    a_rd_addr = 1'b0; #1;
    checks++; if (a_rd_data !== 16'h3333) begin errors++; $display("FAIL drain_reg0 got=%h exp=3333", a_rd_data); end
    a_rd_addr = 1'b1; #1;
    checks++; if (a_rd_data !== 16'h4444) begin errors++; $display("FAIL drain_reg1 got=%h exp=4444", a_rd_data); end
  endtask

  task automatic test_back_to_back();
    a_drain_en = 1'b1;
    a_rd_addr  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_wr_valid = 1'b1;
      a_wr_addr  = 1'b0;
      a_wr_data  = 16'hA000 + 16'(i);
      tick();
      checks++; if (a_pend_count !== 3'd1) begin errors++; $display("FAIL b2b_pend[%0d] got=%0d exp=1", i, a_pend_count); end
      checks++; if (a_commit_valid !== (i > 0)) begin errors++; $display("FAIL b2b_cv[%0d] got=%b exp=%b", i, a_commit_valid, (i > 0)); end
      checks++; if (a_rd_data !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL b2b_fwd[%0d] got=%h exp=%h", i, a_rd_data, 16'hA000 + 16'(i)); end
    end
    a_wr_valid = 1'b0;
    tick();
    checks++; if (a_pend_count !== 3'd0) begin errors++; $display("FAIL b2b_final_pend got=%0d exp=0", a_pend_count); end
    checks++; if (a_commit_valid !== 1'b1) begin errors++; $display("FAIL b2b_final_cv got=%b exp=1", a_commit_valid); end
    checks++; if (a_rd_data !== 16'hA007) begin errors++; $display("FAIL b2b_reg0 got=%h exp=a007", a_rd_data); end
  endtask

  task automatic test_mid_reset();
    logic        addrs [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] datas [3] = '{16'hBEEF, 16'hCAFE, 16'h1234};
    a_drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_wr_valid = 1'b1;
      a_wr_addr  = addrs[i];
      a_wr_data  = datas[i];
      tick();
    end
    a_wr_valid = 1'b0;
    checks++; if (a_pend_count !== 3'd3) begin errors++; $display("FAIL mrst_pre_pend got=%0d exp=3", a_pend_count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (a_pend_count !== 3'd0) begin errors++; $display("FAIL mrst_pend got=%0d exp=0", a_pend_count); end
    a_rd_addr = 1'b0; #1;
    checks++; if (a_rd_data !== 16'h0000) begin errors++; $display("FAIL mrst_rd0 got=%h exp=0000", a_rd_data); end
    a_rd_addr = 1'b1; #1;
    checks++; if (a_rd_data !== 16'h0000) begin errors++; $display("FAIL mrst_rd1 got=%h exp=0000", a_rd_data); end
    a_drain_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (a_commit_valid !== 1'b0) begin errors++; $display("FAIL mrst_cv[%0d] got=%b exp=0", k, a_commit_valid); end
    end
    checks++; if (a_rd_data !== 16'h0000) begin errors++; $display("FAIL mrst_rd1_after got=%h exp=0000", a_rd_data); end
    a_drain_en = 1'b0;
  endtask

  task automatic test_out_of_range();
    b_drain_en = 1'b1;
    b_wr_valid = 1'b1;
    b_wr_addr  = 2'd3;
    b_wr_data  = 16'hDEAD;
    tick();
    b_wr_valid = 1'b0;
    checks++; if (b_pend_count !== 3'd1) begin errors++; $display("FAIL oor_pend got=%0d exp=1", b_pend_count); end
    checks++; if (b_err_oor !== 1'b0) begin errors++; $display("FAIL oor_err_early got=%b exp=0", b_err_oor); end
    b_rd_addr = 2'd3; #1;
    checks++; if (b_rd_data !== 16'hDEAD) begin errors++; $display("FAIL oor_fwd got=%h exp=dead", b_rd_data); end
    tick();
    checks++; if (b_commit_valid !== 1'b1) begin errors++; $display("FAIL oor_cv got=%b exp=1", b_commit_valid); end
    checks++; if (b_commit_addr !== 2'd3) begin errors++; $display("FAIL oor_ca got=%0d exp=3", b_commit_addr); end
    checks++; if (b_err_oor !== 1'b1) begin errors++; $display("FAIL oor_err got=%b exp=1", b_err_oor); end
    checks++; if (b_rd_data !== 16'h0000) begin errors++; $display("FAIL oor_rd3 got=%h exp=0000", b_rd_data); end
    for (int r = 0; r < 3; r++) begin
      b_rd_addr = 2'(r); #1;
      checks++; if (b_rd_data !== 16'h0000) begin errors++; $display("FAIL oor_reg%0d got=%h exp=0000", r, b_rd_data); end
    end
    // A later in-range write lands but leaves the sticky flag set.
    b_wr_valid = 1'b1;
    b_wr_addr  = 2'd2;
    b_wr_data  = 16'h0202;
    tick();
    b_wr_valid = 1'b0;
    tick();
    checks++; if (b_commit_addr !== 2'd2) begin errors++; $display("FAIL oor_ca2 got=%0d exp=2", b_commit_addr); end
    checks++; if (b_err_oor !== 1'b1) begin errors++; $display("FAIL oor_sticky got=%b exp=1", b_err_oor); end
    b_rd_addr = 2'd2; #1;
    checks++; if (b_rd_data !== 16'h0202) begin errors++; $display("FAIL oor_reg2_write got=%h exp=0202", b_rd_data); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (b_err_oor !== 1'b0) begin errors++; $display("FAIL oor_err_clear got=%b exp=0", b_err_oor); end
    b_drain_en = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    a_wr_valid = 1'b0; a_wr_addr = 1'b0; a_wr_data = '0; a_drain_en = 1'b0; a_rd_addr = 1'b0;
    b_wr_valid = 1'b0; b_wr_addr = '0;   b_wr_data = '0; b_drain_en = 1'b0; b_rd_addr = '0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_mid_reset();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
